i2c_master_ctrl: RTL and testbench

// Single-byte I2C bus master: the initiating end for the i2cslave responder.
// On a start pulse it issues START, 7-bit address + R/W, samples the ACK, then

---
 rtl/i2c_master_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-byte I2C bus master.
// A start pulse in IDLE latches addr/rw/wdata and runs one transaction:
// START, 7-bit address + R/W, address ACK, one data byte (write or read),
// data ACK/NACK, STOP. Every phase is built from bits of four quarter periods.
// A quarter period is CLK_DIV clk cycles long.
// Ports:
//   clk, rst        system clock; asynchronous active-high reset
//   start           request pulse, only looked at while idle
//   addr, rw, wdata transaction request, latched on accept
//   rdata           last byte read, updated when the final data bit is sampled
//   busy, done      transaction in progress / one-clk end pulse
//   ack_err         sticky NACK flag, cleared by the next accepted start
//   i2c_scl         push-pull SCL, idles high
//   i2c_sda         open-drain SDA, only ever pulled low
module i2c_master_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       i2c_scl,
  inout  wire        i2c_sda
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_AACK  = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_DACK  = 3'd5;
  localparam logic [2:0] S_STOP  = 3'd6;

  logic [2:0]       state_q,   state_d;
  logic [DIV_W-1:0] div_q,     div_d;
  logic [1:0]       qtr_q,     qtr_d;
  logic [2:0]       bit_q,     bit_d;
  logic [6:0]       addr_q,    addr_d;
  logic             rw_q,      rw_d;
  logic [7:0]       wdata_q,   wdata_d;
  logic [6:0]       shift_q,   shift_d;
  logic [7:0]       rdata_q,   rdata_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic             ack_err_q, ack_err_d;
  logic             scl_q,     scl_d;
  logic             sda_oe_q,  sda_oe_d;

  logic       tick, samp, qend, sda_in;
  logic [7:0] ab_d;

  assign sda_in = i2c_sda;
  assign tick   = (div_q == DIV_W'(CLK_DIV - 1));
  // SDA is sampled on the last clk of q2, one quarter after SCL rose.
  assign samp   = tick && (qtr_q == 2'd2);
  assign qend   = tick && (qtr_q == 2'd3);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    wdata_d   = wdata_q;
    shift_d   = shift_q;
    rdata_d   = rdata_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;

    if (state_q == S_IDLE) begin
      if (start) begin
        addr_d    = addr;
        rw_d      = rw;
        wdata_d   = wdata;
        ack_err_d = 1'b0;
        busy_d    = 1'b1;
        div_d     = '0;
        qtr_d     = 2'd0;
        state_d   = S_START;
      end
    end else begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
      if (tick) qtr_d = qtr_q + 2'd1;
      case (state_q)
        S_START: if (qend) begin
          state_d = S_ADDR;
          bit_d   = 3'd7;
        end
        S_ADDR: if (qend) begin
          if (bit_q == 3'd0) state_d = S_AACK;
          else               bit_d   = bit_q - 3'd1;
        end
        S_AACK: begin
          if (samp && sda_in) ack_err_d = 1'b1;
          // ack_err was cleared on accept, so here it reflects the address ACK only.
          if (qend) begin
            state_d = ack_err_q ? S_STOP : S_DATA;
            bit_d   = 3'd7;
          end
        end
        S_DATA: begin
          if (samp && rw_q) begin
            shift_d = {shift_q[5:0], sda_in};
            if (bit_q == 3'd0) rdata_d = {shift_q, sda_in};
          end
          if (qend) begin
            if (bit_q == 3'd0) state_d = S_DACK;
            else               bit_d   = bit_q - 3'd1;
          end
        end
        S_DACK: begin
          if (samp && !rw_q && sda_in) ack_err_d = 1'b1;
          if (qend) state_d = S_STOP;
        end
        S_STOP: if (qend) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Pin values are computed from the next state so the pins are registered
    // and change on the same edge as the state.
    ab_d     = {addr_d, rw_d};
    scl_d    = 1'b1;
    sda_oe_d = 1'b0;
    case (state_d)
      S_START: sda_oe_d = qtr_d[1];
      S_ADDR: begin
        scl_d    = qtr_d[1];
        sda_oe_d = !ab_d[bit_d];
      end
      S_AACK, S_DACK: scl_d = qtr_d[1];
      S_DATA: begin
        scl_d    = qtr_d[1];
        sda_oe_d = !rw_d && !wdata_d[bit_d];
      end
      S_STOP: begin
        scl_d    = qtr_d[1];
        sda_oe_d = (qtr_d != 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      qtr_q     <= 2'd0;
      bit_q     <= 3'd0;
      addr_q    <= 7'd0;
      rw_q      <= 1'b0;
      wdata_q   <= 8'd0;
      shift_q   <= 7'd0;
      rdata_q   <= 8'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      wdata_q   <= wdata_d;
      shift_q   <= shift_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      scl_q     <= scl_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

  assign rdata   = rdata_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign i2c_scl = scl_q;
  assign i2c_sda = sda_oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: two instances (CLK_DIV=4 and CLK_DIV=1) on
// separate pulled-up SDA buses, each with a simple slave that ACKs 7'h08.
// The slave records the SDA value at every SCL rise; expected bit streams,
// lengths and flags are built from the protocol rules per transaction.
module tb_i2c_master_ctrl;

  localparam logic [6:0] SLV = 7'h08;
  localparam int DIVS [2] = '{4, 1};

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start, rw, busy, done, ack_err, scl;
  logic [1:0] drv;
  logic [6:0] addr  [2];
  logic [7:0] wdata [2];
  logic [7:0] rdata [2];
  wire        sda0, sda1;

  pullup (sda0);
  pullup (sda1);
  assign sda0 = drv[0] ? 1'b0 : 1'bz;
  assign sda1 = drv[1] ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  i2c_master_ctrl #(.CLK_DIV(4)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .addr(addr[0]), .rw(rw[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .busy(busy[0]), .done(done[0]),
    .ack_err(ack_err[0]), .i2c_scl(scl[0]), .i2c_sda(sda0)
  );

  i2c_master_ctrl #(.CLK_DIV(1)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .addr(addr[1]), .rw(rw[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .busy(busy[1]), .done(done[1]),
    .ack_err(ack_err[1]), .i2c_scl(scl[1]), .i2c_sda(sda1)
  );

  // Slave / bus monitor, evaluated on the falling clk edge.
  logic [1:0]  sp, dp, acked, rwb;
  logic [31:0] bits   [2];
  int          nbits  [2];
  int          bidx   [2];
  int          nstart [2];
  int          nstop  [2];
  logic [7:0]  slv_rd [2];
  logic [7:0]  exp_rd [2];
  logic        ms, md;

  always @(negedge clk) begin
    for (int b = 0; b < 2; b++) begin
      ms = scl[b];
      md = (b == 0) ? sda0 : sda1;
      if (rst) begin
        drv[b] = 1'b0;
      end else if (sp[b] && ms && dp[b] && !md) begin
        nstart[b] = nstart[b] + 1;
        nbits[b]  = 0;
        bits[b]   = '0;
        bidx[b]   = -1;
        drv[b]    = 1'b0;
      end else if (sp[b] && ms && !dp[b] && md) begin
        nstop[b] = nstop[b] + 1;
      end else if (!sp[b] && ms) begin
        bits[b]  = {bits[b][30:0], md};
        nbits[b] = nbits[b] + 1;
      end else if (sp[b] && !ms) begin
        bidx[b] = bidx[b] + 1;
        if (bidx[b] == 8) begin
          acked[b] = (bits[b][7:1] == SLV);
          rwb[b]   = bits[b][0];
          drv[b]   = acked[b];
        end else if (bidx[b] >= 9 && bidx[b] <= 16 && acked[b] && rwb[b])
          drv[b] = !slv_rd[b][3'(16 - bidx[b])];
        else if (bidx[b] == 17 && acked[b] && !rwb[b])
          drv[b] = 1'b1;
        else
          drv[b] = 1'b0;
      end
      sp[b] = ms;
      dp[b] = md;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; start is seen by the following rising edge.
  task automatic launch(input int b, input logic [6:0] a, input logic r,
                        input logic [7:0] w, output int acc, output int st0, output int sp0);
    addr[b]  = a;
    rw[b]    = r;
    wdata[b] = w;
    start[b] = 1'b1;
    st0 = nstart[b];
    sp0 = nstop[b];
    @(negedge clk);
    start[b] = 1'b0;
    acc = cyc;
    chk("busy_rise", 32'(busy[b]), 32'd1);
    chk("done_low", 32'(done[b]), 32'd0);
  endtask

  // Returns at the falling edge where done is high.
  task automatic finish_chk(input int b, input logic [6:0] a, input logic r,
                            input logic [7:0] w, input int acc, input int st0, input int sp0);
    logic        ok;
    logic [31:0] eb;
    int          en, t;
    ok = (a == SLV);
    if (!ok) begin
      eb = {22'd0, a, r, 1'b1, 1'b0};
      en = 10;
    end else if (r) begin
      eb = {13'd0, a, r, 1'b0, slv_rd[b], 1'b1, 1'b0};
      en = 19;
      exp_rd[b] = slv_rd[b];
    end else begin
      eb = {13'd0, a, r, 1'b0, w, 1'b0, 1'b0};
      en = 19;
    end
    t = 0;
    while (done[b] !== 1'b1 && t < 200 * DIVS[b]) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", 32'(done[b]), 32'd1);
    chk("latency", 32'(cyc - acc), 32'((ok ? 80 : 44) * DIVS[b]));
    chk("busy_fall", 32'(busy[b]), 32'd0);
    chk("nbits", 32'(nbits[b]), 32'(en));
    chk("bits", bits[b], eb);
    chk("ack_err", 32'(ack_err[b]), 32'(!ok));
    chk("rdata", 32'(rdata[b]), 32'(exp_rd[b]));
    chk("start_cond", 32'(nstart[b]), 32'(st0 + 1));
    chk("stop_cond", 32'(nstop[b]), 32'(sp0 + 1));
    chk("sda_idle", 32'((b == 0) ? sda0 : sda1), 32'd1);
  endtask

  int         acc, st0, sp0;
  logic [6:0] ra;
  logic       rr;
  logic [7:0] rwd;

  initial begin
    sp = 2'b11; dp = 2'b11; drv = 2'b00; acked = 2'b00; rwb = 2'b00;
    for (int b = 0; b < 2; b++) begin
      bits[b] = '0; nbits[b] = 0; bidx[b] = -1; nstart[b] = 0; nstop[b] = 0;
      slv_rd[b] = 8'h00; exp_rd[b] = 8'h00;
      addr[b] = 7'h0; wdata[b] = 8'h0;
    end
    start = 2'b00; rw = 2'b00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      chk("rst_scl", 32'(scl[b]), 32'd1);
      chk("rst_busy", 32'(busy[b]), 32'd0);
      chk("rst_done", 32'(done[b]), 32'd0);
      chk("rst_ackerr", 32'(ack_err[b]), 32'd0);
      chk("rst_rdata", 32'(rdata[b]), 32'd0);
    end
    chk("rst_sda", 32'(sda0), 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: write 08/A5, ACKed
    launch(0, 7'h08, 1'b0, 8'hA5, acc, st0, sp0);
    finish_chk(0, 7'h08, 1'b0, 8'hA5, acc, st0, sp0);
    repeat (3) @(negedge clk);

    // 2: write to absent slave -> address NACK, short transaction
    launch(0, 7'h15, 1'b0, 8'h77, acc, st0, sp0);
    finish_chk(0, 7'h15, 1'b0, 8'h77, acc, st0, sp0);
    @(negedge clk);
    chk("ackerr_sticky", 32'(ack_err[0]), 32'd1);
    repeat (2) @(negedge clk);

    // 3: read 3C
    slv_rd[0] = 8'h3C;
    launch(0, 7'h08, 1'b1, 8'h00, acc, st0, sp0);
    finish_chk(0, 7'h08, 1'b1, 8'h00, acc, st0, sp0);
    repeat (2) @(negedge clk);

    // 4: start mid-ADDR ignored, then back-to-back start right after done
    launch(0, 7'h08, 1'b0, 8'hC3, acc, st0, sp0);
    repeat (40) @(negedge clk);
    addr[0] = 7'h15; wdata[0] = 8'hFF; rw[0] = 1'b1; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    chk("busy_mid", 32'(busy[0]), 32'd1);
    finish_chk(0, 7'h08, 1'b0, 8'hC3, acc, st0, sp0);
    slv_rd[0] = 8'h96;
    launch(0, 7'h08, 1'b1, 8'h00, acc, st0, sp0);
    finish_chk(0, 7'h08, 1'b1, 8'h00, acc, st0, sp0);
    repeat (2) @(negedge clk);

    // 5: reset mid-DATA, then a normal write
    launch(0, 7'h08, 1'b0, 8'hA5, acc, st0, sp0);
    repeat (180) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_scl", 32'(scl[0]), 32'd1);
    chk("arst_sda", 32'(sda0), 32'd1);
    chk("arst_busy", 32'(busy[0]), 32'd0);
    chk("arst_rdata", 32'(rdata[0]), 32'd0);
    exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    launch(0, 7'h08, 1'b0, 8'h5A, acc, st0, sp0);
    finish_chk(0, 7'h08, 1'b0, 8'h5A, acc, st0, sp0);
    repeat (2) @(negedge clk);

    // 6: CLK_DIV=1 instance, same write as test 1
    launch(1, 7'h08, 1'b0, 8'hA5, acc, st0, sp0);
    finish_chk(1, 7'h08, 1'b0, 8'hA5, acc, st0, sp0);
    repeat (2) @(negedge clk);

    // Randomized transactions on both instances
    for (int i = 0; i < 12; i++) begin
      ra  = ($urandom_range(0, 1) == 1) ? SLV : 7'($urandom);
      rr  = 1'($urandom);
      rwd = 8'($urandom);
      slv_rd[i % 2] = 8'($urandom);
      launch(i % 2, ra, rr, rwd, acc, st0, sp0);
      finish_chk(i % 2, ra, rr, rwd, acc, st0, sp0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
